// File: rtl/rd_arbiter_if.sv
// Read-channel signal bundle for rd_arbiter: IF and MEM requesters, AXI bridge side, and grant.
// slave = arbiter view, master = environment (requesters + bridge) view.
interface rd_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) ();
  logic              if_r_valid;
  logic              if_r_ready;
  logic [ADDR_W-1:0] if_r_addr;
  logic [7:0]        if_r_size;
  logic              if_data_valid;
  logic              if_data_ready;
  logic [DATA_W-1:0] if_data;

  logic              mem_r_valid;
  logic              mem_r_ready;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [7:0]        mem_r_size;
  logic              mem_data_valid;
  logic              mem_data_ready;
  logic [DATA_W-1:0] mem_data;

  logic              rx_r_valid_i;
  logic              rx_r_ready_o;
  logic [ADDR_W-1:0] rx_r_addr_i;
  logic [7:0]        rx_r_size_i;
  logic [DATA_W-1:0] rx_data_read_o;
  logic              rx_data_valid;
  logic              rx_data_ready;

  logic [1:0]        grant_o;

  modport slave (
    input  if_r_valid, if_r_addr, if_r_size, if_data_ready,
    input  mem_r_valid, mem_r_addr, mem_r_size, mem_data_ready,
    input  rx_r_ready_o, rx_data_read_o, rx_data_valid,
    output if_r_ready, if_data_valid, if_data,
    output mem_r_ready, mem_data_valid, mem_data,
    output rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
    output grant_o
  );

  modport master (
    output if_r_valid, if_r_addr, if_r_size, if_data_ready,
    output mem_r_valid, mem_r_addr, mem_r_size, mem_data_ready,
    output rx_r_ready_o, rx_data_read_o, rx_data_valid,
    input  if_r_ready, if_data_valid, if_data,
    input  mem_r_ready, mem_data_valid, mem_data,
    input  rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
    input  grant_o
  );
endinterface

// File: rtl/rd_arbiter.sv
// rd_arbiter: one AXI-style read channel shared by IF and MEM, one transaction in flight, >=3 cycles each.
// r_ready only in IDLE, data is a zero-latency pass-through; RD_ARB_RR_EN selects round-robin over MEM priority.
module rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic      clk,
  input logic      rst,
  rd_arbiter_if.slave bus
);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_MEM  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        size;
  } req_t;

  state_t            state;
  logic [1:0]        owner;
  logic              rx_vld_q;
  logic [ADDR_W-1:0] rx_addr_q;
  logic [7:0]        rx_size_q;
`ifdef RD_ARB_RR_EN
  logic [1:0]        last_owner;
`endif

  logic [1:0] winner;
  req_t       win_req;
  logic       accept;
  logic       own_if;
  logic       own_mem;
  logic       data_hs;

  always_comb begin
    winner = OWN_NONE;
    if (bus.if_r_valid && bus.mem_r_valid) begin
`ifdef RD_ARB_RR_EN
      winner = (last_owner == OWN_MEM) ? OWN_IF : OWN_MEM;
`else
      // A stalled load costs more than a delayed fetch.
      winner = OWN_MEM;
`endif
    end else if (bus.mem_r_valid) begin
      winner = OWN_MEM;
    end else if (bus.if_r_valid) begin
      winner = OWN_IF;
    end
  end

  always_comb begin
    win_req = '0;
    if (winner == OWN_MEM) begin
      win_req.addr = bus.mem_r_addr;
      win_req.size = bus.mem_r_size;
    end else if (winner == OWN_IF) begin
      win_req.addr = bus.if_r_addr;
      win_req.size = bus.if_r_size;
    end
  end

  assign accept          = (state == IDLE) && !rst && (winner != OWN_NONE);
  assign bus.if_r_ready  = accept && (winner == OWN_IF);
  assign bus.mem_r_ready = accept && (winner == OWN_MEM);

  assign own_if  = (state == DATA) && (owner == OWN_IF);
  assign own_mem = (state == DATA) && (owner == OWN_MEM);

  assign bus.rx_data_ready  = (own_if && bus.if_data_ready) || (own_mem && bus.mem_data_ready);
  assign bus.if_data_valid  = own_if && bus.rx_data_valid;
  assign bus.mem_data_valid = own_mem && bus.rx_data_valid;
  assign bus.if_data        = own_if  ? bus.rx_data_read_o : '0;
  assign bus.mem_data       = own_mem ? bus.rx_data_read_o : '0;
  assign data_hs            = bus.rx_data_valid && bus.rx_data_ready;

  assign bus.rx_r_valid_i = rx_vld_q;
  assign bus.rx_r_addr_i  = rx_addr_q;
  assign bus.rx_r_size_i  = rx_size_q;
  assign bus.grant_o      = (state == IDLE) ? OWN_NONE : owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      rx_vld_q  <= 1'b0;
      rx_addr_q <= '0;
      rx_size_q <= '0;
`ifdef RD_ARB_RR_EN
      last_owner <= OWN_MEM;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            owner     <= winner;
            rx_addr_q <= win_req.addr;
            rx_size_q <= win_req.size;
            rx_vld_q  <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          // Address held stable until the bridge takes it.
          if (rx_vld_q && bus.rx_r_ready_o) begin
            rx_vld_q <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (data_hs) begin
`ifdef RD_ARB_RR_EN
            last_owner <= owner;
`endif
            owner <= OWN_NONE;
            state <= IDLE;
          end
        end
        default: begin
          owner    <= OWN_NONE;
          rx_vld_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_arbiter.sv
// Bench for rd_arbiter: directed scenarios plus a randomized stress run against a transaction-level model.
module tb_rd_arbiter;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_IF   = 2'b01;
  localparam logic [1:0] G_MEM  = 2'b10;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [1:0] m_last;

  rd_arbiter_if bus ();
  rd_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [63:0] fdat(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, a[63:32] ^ 32'h1357_9BDF};
  endfunction

  // Arbitration rule: lone requester wins; on a tie MEM wins, or the non-last owner under round-robin.
  function automatic logic [1:0] pick(input logic p_if, input logic p_mem);
    if (p_if && p_mem) begin
`ifdef RD_ARB_RR_EN
      return (m_last == G_MEM) ? G_IF : G_MEM;
`else
      return G_MEM;
`endif
    end
    if (p_mem) return G_MEM;
    if (p_if) return G_IF;
    return G_NONE;
  endfunction

  task automatic idle_inputs();
    bus.if_r_valid     = 1'b0;
    bus.if_r_addr      = '0;
    bus.if_r_size      = '0;
    bus.if_data_ready  = 1'b0;
    bus.mem_r_valid    = 1'b0;
    bus.mem_r_addr     = '0;
    bus.mem_r_size     = '0;
    bus.mem_data_ready = 1'b0;
    bus.rx_r_ready_o   = 1'b0;
    bus.rx_data_read_o = '0;
    bus.rx_data_valid  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction for the requester 'who', whose request is already driven and we are in IDLE.
  task automatic do_txn(input logic [1:0] who, input logic [63:0] a, input logic [7:0] sz,
                        input int alat, input int dlat, input int bp,
                        input logic [63:0] d, input string tag);
    logic [63:0] drv_d;
    logic        od_v, nd_v, exp_dv, exp_rdy;
    logic [63:0] od, nd;
    $display("txn %s: owner %0d, previous owner %0d", tag, who, m_last);
    @(negedge clk);
    n_chk++;
    if ({bus.mem_r_ready, bus.if_r_ready} !== who || bus.grant_o !== G_NONE) begin
      n_fail++;
      $display("FAIL %s accept: ready{mem,if}=%b grant=%b, expected %b and 00",
               tag, {bus.mem_r_ready, bus.if_r_ready}, bus.grant_o, who);
    end
    tick();
    if (who == G_IF) bus.if_r_valid = 1'b0;
    else bus.mem_r_valid = 1'b0;
    for (int i = 0; i <= alat; i++) begin
      bus.rx_r_ready_o = (i == alat);
      @(negedge clk);
      n_chk++;
      if (bus.rx_r_valid_i !== 1'b1 || bus.rx_r_addr_i !== a || bus.rx_r_size_i !== sz ||
          bus.grant_o !== who || {bus.mem_r_ready, bus.if_r_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s addr_phase c%0d: vld=%b addr=%h size=%h grant=%b rdy=%b, expected 1 %h %h %b 00",
                 tag, i, bus.rx_r_valid_i, bus.rx_r_addr_i, bus.rx_r_size_i, bus.grant_o,
                 {bus.mem_r_ready, bus.if_r_ready}, a, sz, who);
      end
      tick();
    end
    bus.rx_r_ready_o = 1'b0;
    for (int j = 0; j < dlat + bp + 1; j++) begin
      exp_dv  = (j >= dlat);
      exp_rdy = (j == dlat + bp);
      drv_d   = exp_dv ? d : {$urandom, $urandom};
      bus.rx_data_valid  = exp_dv;
      bus.rx_data_read_o = drv_d;
      bus.if_data_ready  = (who == G_IF)  ? exp_rdy : 1'b1;
      bus.mem_data_ready = (who == G_MEM) ? exp_rdy : 1'b1;
      @(negedge clk);
      od_v = (who == G_IF) ? bus.if_data_valid : bus.mem_data_valid;
      od   = (who == G_IF) ? bus.if_data : bus.mem_data;
      nd_v = (who == G_IF) ? bus.mem_data_valid : bus.if_data_valid;
      nd   = (who == G_IF) ? bus.mem_data : bus.if_data;
      n_chk++;
      if (od_v !== exp_dv || od !== drv_d || bus.rx_data_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s data_owner c%0d: dv=%b data=%h rx_rdy=%b, expected %b %h %b",
                 tag, j, od_v, od, bus.rx_data_ready, exp_dv, drv_d, exp_rdy);
      end
      n_chk++;
      if (nd_v !== 1'b0 || nd !== 64'h0 || bus.grant_o !== who || bus.rx_r_valid_i !== 1'b0 ||
          {bus.mem_r_ready, bus.if_r_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s data_other c%0d: dv=%b data=%h grant=%b rx_vld=%b rdy=%b, expected 0 0 %b 0 00",
                 tag, j, nd_v, nd, bus.grant_o, bus.rx_r_valid_i, {bus.mem_r_ready, bus.if_r_ready}, who);
      end
      tick();
    end
    bus.rx_data_valid  = 1'b0;
    bus.rx_data_read_o = '0;
    bus.if_data_ready  = 1'b0;
    bus.mem_data_ready = 1'b0;
    m_last = who;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.rx_data_valid  = 1'b1;
    bus.rx_data_read_o = {$urandom, $urandom};
    m_last = G_MEM;
    @(negedge clk);
    n_chk++;
    if ({bus.grant_o, bus.rx_r_valid_i, bus.rx_data_ready, bus.if_r_ready, bus.mem_r_ready,
         bus.if_data_valid, bus.mem_data_valid} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: grant=%b rx_vld=%b rx_rdy=%b rdy=%b%b dv=%b%b, expected all 0",
               bus.grant_o, bus.rx_r_valid_i, bus.rx_data_ready, bus.if_r_ready, bus.mem_r_ready,
               bus.if_data_valid, bus.mem_data_valid);
    end
    n_chk++;
    if (bus.rx_r_addr_i !== 64'h0 || bus.rx_r_size_i !== 8'h0 || bus.if_data !== 64'h0 || bus.mem_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h size=%h if_data=%h mem_data=%h, expected all 0",
               bus.rx_r_addr_i, bus.rx_r_size_i, bus.if_data, bus.mem_data);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    logic [1:0] first, second;
    bus.if_r_valid  = 1'b1;
    bus.if_r_addr   = 64'h8000_0004;
    bus.if_r_size   = 8'h0F;
    bus.mem_r_valid = 1'b1;
    bus.mem_r_addr  = 64'h8000_1000;
    bus.mem_r_size  = 8'h03;
    first  = pick(1'b1, 1'b1);
    second = (first == G_IF) ? G_MEM : G_IF;
    do_txn(first, (first == G_IF) ? 64'h8000_0004 : 64'h8000_1000, (first == G_IF) ? 8'h0F : 8'h03,
           0, 1, 0, 64'h1111_2222_3333_4444, "simul_first");
    do_txn(second, (second == G_IF) ? 64'h8000_0004 : 64'h8000_1000, (second == G_IF) ? 8'h0F : 8'h03,
           1, 0, 0, 64'h5555_6666_7777_8888, "simul_second");
  endtask

  task automatic test_single_if();
    bus.if_r_valid = 1'b1;
    bus.if_r_addr  = 64'h8000_0000;
    bus.if_r_size  = 8'h0F;
    do_txn(G_IF, 64'h8000_0000, 8'h0F, 0, 2, 0, 64'h0000_0013_0000_0093, "single_if");
  endtask

  task automatic test_backpressure();
    bus.mem_r_valid = 1'b1;
    bus.mem_r_addr  = 64'h8000_2040;
    bus.mem_r_size  = 8'hFF;
    do_txn(G_MEM, 64'h8000_2040, 8'hFF, 5, 0, 3, 64'hCAFE_F00D_0BAD_BEEF, "backpressure");
  endtask

  task automatic test_stray();
    for (int i = 0; i < 3; i++) begin
      bus.rx_data_valid  = 1'b1;
      bus.rx_data_read_o = {$urandom, $urandom};
      bus.if_data_ready  = 1'b1;
      bus.mem_data_ready = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.if_data_valid !== 1'b0 || bus.mem_data_valid !== 1'b0 || bus.rx_data_ready !== 1'b0 ||
          bus.if_data !== 64'h0 || bus.mem_data !== 64'h0 || bus.grant_o !== G_NONE) begin
        n_fail++;
        $display("FAIL stray c%0d: dv=%b%b rx_rdy=%b data=%h/%h grant=%b, expected all 0",
                 i, bus.if_data_valid, bus.mem_data_valid, bus.rx_data_ready, bus.if_data, bus.mem_data, bus.grant_o);
      end
      tick();
    end
    idle_inputs();
    bus.if_r_valid = 1'b1;
    bus.if_r_addr  = 64'h8000_0100;
    bus.if_r_size  = 8'h0F;
    do_txn(G_IF, 64'h8000_0100, 8'h0F, 0, 0, 0, 64'h0123_4567_89AB_CDEF, "after_stray");
  endtask

  task automatic test_reset_in_data();
    bus.if_r_valid = 1'b1;
    bus.if_r_addr  = 64'h8000_0200;
    bus.if_r_size  = 8'h0F;
    tick();
    bus.if_r_valid   = 1'b0;
    bus.rx_r_ready_o = 1'b1;
    tick();
    bus.rx_r_ready_o = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.grant_o !== G_IF || bus.rx_r_valid_i !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_data_setup: grant=%b rx_vld=%b, expected 01 0", bus.grant_o, bus.rx_r_valid_i);
    end
    tick();
    rst = 1'b1;
    bus.rx_data_valid  = 1'b1;
    bus.rx_data_read_o = 64'hFFFF_0000_FFFF_0000;
    bus.if_data_ready  = 1'b1;
    tick();
    rst = 1'b0;
    m_last = G_MEM;
    @(negedge clk);
    n_chk++;
    if ({bus.grant_o, bus.rx_r_valid_i, bus.rx_data_ready, bus.if_r_ready, bus.mem_r_ready,
         bus.if_data_valid, bus.mem_data_valid} !== 8'h00 || bus.rx_r_addr_i !== 64'h0 ||
        bus.rx_r_size_i !== 8'h0 || bus.if_data !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_in_data: grant=%b rx_vld=%b rx_rdy=%b dv=%b addr=%h size=%h data=%h, expected all 0",
               bus.grant_o, bus.rx_r_valid_i, bus.rx_data_ready, bus.if_data_valid,
               bus.rx_r_addr_i, bus.rx_r_size_i, bus.if_data);
    end
    tick();
    idle_inputs();
    bus.if_r_valid = 1'b1;
    bus.if_r_addr  = 64'h8000_0300;
    bus.if_r_size  = 8'h0F;
    do_txn(G_IF, 64'h8000_0300, 8'h0F, 1, 1, 0, 64'hA5A5_5A5A_A5A5_5A5A, "after_reset");
  endtask

  task automatic test_stress();
    logic        p_if = 1'b0, p_mem = 1'b0, busy = 1'b0, indata;
    logic [63:0] a_if = '0, a_mem = '0, cur_a = '0, d_val = '0, e_if_d, e_mem_d;
    logic [7:0]  s_if = '0, s_mem = '0, cur_s = '0;
    logic [1:0]  cur = G_NONE, win, gq;
    logic        e_if_dv, e_mem_dv, e_rdy, hs_a, hs_d;
    logic [1:0]  grant_q[$];
    int issued = 0, acc_if = 0, acc_mem = 0, beats_if = 0, beats_mem = 0;
    int a_wait = -1, d_wait = -1, outst = 0, cyc = 0;
    while (!(issued == 50 && !p_if && !p_mem && !busy) && cyc < 20000) begin
      if (!p_if && issued < 50 && $urandom_range(0, 2) == 0) begin
        p_if = 1'b1; issued++;
        a_if = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFF8)};
        s_if = 8'($urandom);
      end
      if (!p_mem && issued < 50 && $urandom_range(0, 2) == 0) begin
        p_mem = 1'b1; issued++;
        a_mem = {32'h0, 32'h9000_0000 | ($urandom & 32'h0000_FFF8)};
        s_mem = 8'($urandom);
      end
      bus.if_r_valid  = p_if;  bus.if_r_addr  = a_if;  bus.if_r_size  = s_if;
      bus.mem_r_valid = p_mem; bus.mem_r_addr = a_mem; bus.mem_r_size = s_mem;
      if (bus.rx_r_valid_i && a_wait < 0) a_wait = $urandom_range(0, 4);
      bus.rx_r_ready_o = (a_wait == 0);
      if (d_wait == 0) begin
        bus.rx_data_valid = 1'b1; bus.rx_data_read_o = d_val;
      end else begin
        bus.rx_data_valid  = (d_wait < 0) && ($urandom_range(0, 5) == 0);
        bus.rx_data_read_o = {$urandom, $urandom};
      end
      bus.if_data_ready  = $urandom_range(0, 1) == 1;
      bus.mem_data_ready = $urandom_range(0, 1) == 1;
      @(negedge clk);
      win = busy ? G_NONE : pick(p_if, p_mem);
      n_chk++;
      if ({bus.mem_r_ready, bus.if_r_ready} !== win || bus.grant_o !== (busy ? cur : G_NONE)) begin
        n_fail++;
        $display("FAIL stress_arb cyc%0d: ready{mem,if}=%b grant=%b, expected %b %b",
                 cyc, {bus.mem_r_ready, bus.if_r_ready}, bus.grant_o, win, busy ? cur : G_NONE);
      end
      indata   = (d_wait >= 0);
      e_if_dv  = indata && (cur == G_IF) && bus.rx_data_valid;
      e_mem_dv = indata && (cur == G_MEM) && bus.rx_data_valid;
      e_rdy    = indata && ((cur == G_IF) ? bus.if_data_ready : bus.mem_data_ready);
      e_if_d   = (indata && cur == G_IF)  ? bus.rx_data_read_o : 64'h0;
      e_mem_d  = (indata && cur == G_MEM) ? bus.rx_data_read_o : 64'h0;
      n_chk++;
      if ({bus.if_data_valid, bus.mem_data_valid, bus.rx_data_ready} !== {e_if_dv, e_mem_dv, e_rdy} ||
          bus.if_data !== e_if_d || bus.mem_data !== e_mem_d) begin
        n_fail++;
        $display("FAIL stress_data cyc%0d: dv=%b%b rx_rdy=%b data=%h/%h, expected %b%b %b %h/%h",
                 cyc, bus.if_data_valid, bus.mem_data_valid, bus.rx_data_ready, bus.if_data, bus.mem_data,
                 e_if_dv, e_mem_dv, e_rdy, e_if_d, e_mem_d);
      end
      hs_a = bus.rx_r_valid_i && bus.rx_r_ready_o;
      hs_d = bus.rx_data_valid && bus.rx_data_ready;
      if (hs_a) begin
        n_chk++;
        if (bus.rx_r_addr_i !== cur_a || bus.rx_r_size_i !== cur_s || !busy || outst != 0) begin
          n_fail++;
          $display("FAIL stress_addr cyc%0d: addr=%h size=%h busy=%b outstanding=%0d, expected %h %h 1 0",
                   cyc, bus.rx_r_addr_i, bus.rx_r_size_i, busy, outst, cur_a, cur_s);
        end
        outst  = 1;
        a_wait = -1;
        d_wait = $urandom_range(0, 4);
        d_val  = fdat(cur_a);
      end else if (a_wait > 0) begin
        a_wait--;
      end
      if (hs_d && indata) begin
        gq = grant_q.pop_front();
        n_chk++;
        if (gq !== cur || bus.rx_data_read_o !== fdat(cur_a)) begin
          n_fail++;
          $display("FAIL stress_order cyc%0d: beat owner %b data %h, expected %b %h",
                   cyc, cur, bus.rx_data_read_o, gq, fdat(cur_a));
        end
        if (cur == G_IF) beats_if++; else beats_mem++;
        busy = 1'b0; outst = 0; d_wait = -1; m_last = cur;
      end else if (d_wait > 0) begin
        d_wait--;
      end
      if (win != G_NONE) begin
        busy = 1'b1; cur = win;
        cur_a = (win == G_IF) ? a_if : a_mem;
        cur_s = (win == G_IF) ? s_if : s_mem;
        if (win == G_IF) begin p_if = 1'b0; acc_if++; end
        else begin p_mem = 1'b0; acc_mem++; end
        grant_q.push_back(win);
      end
      tick();
      cyc++;
    end
    n_chk++;
    if (cyc >= 20000) begin
      n_fail++;
      $display("FAIL stress_timeout: %0d cycles used, required fewer than 20000", cyc);
    end
    n_chk++;
    if (beats_if != acc_if || beats_mem != acc_mem || acc_if + acc_mem != 50 || grant_q.size() != 0) begin
      n_fail++;
      $display("FAIL stress_count: beats if/mem=%0d/%0d accepted=%0d/%0d left=%0d, expected beats=accepted, total 50, left 0",
               beats_if, beats_mem, acc_if, acc_mem, grant_q.size());
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_simultaneous();
    test_single_if();
    test_backpressure();
    test_stray();
    test_reset_in_data();
    test_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
